// File: rtl/usb_rx_nrzi_unstuff_pkg.sv
// Shared types and constants for the USB receive front end.
// Line classification lives here so the decoder and any future line monitor agree.
package usb_rx_pkg;

  typedef enum logic [1:0] {LS_J, LS_K, LS_SE0, LS_SE1} line_state_t;

  typedef enum logic [2:0] {HUNT, DATA, EOP1, EOP2, ERR} rx_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_STUFF = 2'd0;
  localparam err_code_t ERR_EOP   = 2'd1;
  localparam err_code_t ERR_LINE  = 2'd2;
  localparam err_code_t ERR_LEN   = 2'd3;

  // A run of this many 1s must be followed by a stuffed 0
  localparam logic [2:0] STUFF_RUN = 3'd6;

  function automatic line_state_t classify(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      2'b00:   return LS_SE0;
      default: return LS_SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_nrzi_unstuff_if.sv
// Line-sample inputs and decoded bit-stream outputs of the receive front end.
// master = the receiver itself, slave = line driver / packet decoder side.
interface usb_rx_if;
  import usb_rx_pkg::*;

  logic      dp;
  logic      dm;
  logic      sample_en;
  logic      bit_out;
  logic      bit_out_avail;
  logic      done;
  logic      rx_active;
  logic      err;
  err_code_t err_code;

  modport master (
    input  dp, dm, sample_en,
    output bit_out, bit_out_avail, done, rx_active, err, err_code
  );

  modport slave (
    output dp, dm, sample_en,
    input  bit_out, bit_out_avail, done, rx_active, err, err_code
  );

endinterface

// File: rtl/usb_rx_nrzi_unstuff_dec.sv
// Line classification and NRZI decode; prev_level is the only state here.
// Outputs are meaningful only while sample_vld is high.
module usb_nrzi_dec
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        dp,
  input  logic        dm,
  input  logic        sample_en,
  output line_state_t line_state,
  output logic        bit_dec,
  output logic        sample_vld
);

  logic        prev_j_q, prev_j_d;
  line_state_t ls;

  assign ls         = classify(dp, dm);
  assign sample_vld = sample_en;

  // SE0/SE1 leave the reference level untouched
  always_comb begin
    prev_j_d   = prev_j_q;
    line_state = LS_SE0;
    bit_dec    = 1'b0;
    if (sample_en) begin
      line_state = ls;
      if (ls == LS_J || ls == LS_K) begin
        bit_dec  = ((ls == LS_J) == prev_j_q);
        prev_j_d = (ls == LS_J);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) prev_j_q <= 1'b1;
    else        prev_j_q <= prev_j_d;
  end

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive front end: SYNC hunt, bit unstuffing, EOP detection and error resolution.
// Emits unstuffed bits starting at PID bit 0, with a done pulse on a clean EOP.
module usb_rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 6,
  parameter int MAX_BITS       = 99,
  parameter int IDLE_RECOVER   = 8
) (
  input  logic     clk,
  input  logic     rst_b,
  usb_rx_if.master rx
);

  localparam logic [2:0] SYNC_Z = 3'(SYNC_MIN_ZEROS);
  localparam logic [6:0] MAX_B  = 7'(MAX_BITS);
  localparam logic [3:0] IDLE_Z = 4'(IDLE_RECOVER);

  line_state_t ls;
  logic        dec_bit;
  logic        smp_vld;

  usb_nrzi_dec u_dec (
    .clk        (clk),
    .rst_b      (rst_b),
    .dp         (rx.dp),
    .dm         (rx.dm),
    .sample_en  (rx.sample_en),
    .line_state (ls),
    .bit_dec    (dec_bit),
    .sample_vld (smp_vld)
  );

  rx_state_t state_q, state_d;
  logic [2:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [6:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       se0_seen_q, se0_seen_d;
  logic       bit_out_q, bit_out_d;
  logic       avail_q, avail_d;
  logic       done_q, done_d;
  logic       active_q, active_d;
  logic       err_q, err_d;
  err_code_t  err_code_q, err_code_d;

  logic       fail;
  err_code_t  fail_code;
  logic       to_hunt;

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    ones_cnt_d = ones_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    se0_seen_d = se0_seen_q;
    bit_out_d  = bit_out_q;
    avail_d    = 1'b0;
    done_d     = 1'b0;
    active_d   = active_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = ERR_STUFF;
    to_hunt    = 1'b0;

    if (smp_vld) begin
      case (state_q)
        HUNT: begin
          case (ls)
            LS_J, LS_K: begin
              if (!dec_bit) begin
                zero_cnt_d = (zero_cnt_q >= SYNC_Z) ? SYNC_Z : zero_cnt_q + 3'd1;
              end else if (zero_cnt_q >= SYNC_Z) begin
                // SYNC's trailing 1 opens the first stuffing run
                state_d    = DATA;
                active_d   = 1'b1;
                ones_cnt_d = 3'd1;
                bit_cnt_d  = 7'd0;
                zero_cnt_d = 3'd0;
              end else begin
                zero_cnt_d = 3'd0;
              end
            end
            LS_SE1: begin
              fail      = 1'b1;
              fail_code = ERR_LINE;
            end
            default: ;
          endcase
        end
        DATA: begin
          case (ls)
            LS_J, LS_K: begin
              if (ones_cnt_q == STUFF_RUN) begin
                if (dec_bit) begin
                  fail      = 1'b1;
                  fail_code = ERR_STUFF;
                end else begin
                  ones_cnt_d = 3'd0;
                end
              end else if (bit_cnt_q == MAX_B) begin
                fail      = 1'b1;
                fail_code = ERR_LEN;
              end else begin
                avail_d    = 1'b1;
                bit_out_d  = dec_bit;
                ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
                bit_cnt_d  = bit_cnt_q + 7'd1;
              end
            end
            LS_SE0:  state_d = EOP1;
            default: begin
              fail      = 1'b1;
              fail_code = ERR_LINE;
            end
          endcase
        end
        EOP1: begin
          if (ls == LS_SE0) begin
            state_d = EOP2;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_EOP;
          end
        end
        EOP2: begin
          if (ls == LS_J) begin
            done_d   = 1'b1;
            active_d = 1'b0;
            to_hunt  = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_EOP;
          end
        end
        ERR: begin
          case (ls)
            LS_J: begin
              if (se0_seen_q || (idle_cnt_q + 4'd1) >= IDLE_Z) begin
                to_hunt = 1'b1;
              end else begin
                idle_cnt_d = (idle_cnt_q == 4'hF) ? idle_cnt_q : idle_cnt_q + 4'd1;
                se0_seen_d = 1'b0;
              end
            end
            LS_SE0: begin
              se0_seen_d = 1'b1;
              idle_cnt_d = 4'd0;
            end
            default: begin
              se0_seen_d = 1'b0;
              idle_cnt_d = 4'd0;
            end
          endcase
        end
        default: to_hunt = 1'b1;
      endcase

      // Every HUNT return happens on a J sample, so the decoder's prev_level is already J
      if (to_hunt) begin
        state_d    = HUNT;
        zero_cnt_d = 3'd0;
        idle_cnt_d = 3'd0;
        se0_seen_d = 1'b0;
      end

      if (fail) begin
        state_d    = ERR;
        err_d      = 1'b1;
        err_code_d = fail_code;
        active_d   = 1'b0;
        avail_d    = 1'b0;
        idle_cnt_d = 4'd0;
        se0_seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= HUNT;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      se0_seen_q <= 1'b0;
      bit_out_q  <= 1'b0;
      avail_q    <= 1'b0;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_STUFF;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      se0_seen_q <= se0_seen_d;
      bit_out_q  <= bit_out_d;
      avail_q    <= avail_d;
      done_q     <= done_d;
      active_q   <= active_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign rx.bit_out       = bit_out_q;
  assign rx.bit_out_avail = avail_q;
  assign rx.done          = done_q;
  assign rx.rx_active     = active_q;
  assign rx.err           = err_q;
  assign rx.err_code      = err_code_q;

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Bench for usb_rx_nrzi_unstuff: cycle-exact vector table for a short ACK packet,
// then NRZI/stuffing encoder driving a bit and event scoreboard for the corner cases.
module tb_usb_rx_nrzi_unstuff;
  import usb_rx_pkg::*;

  localparam int EV_DONE = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  usb_rx_if u_if ();

  usb_rx_nrzi_unstuff dut (
    .clk   (clk),
    .rst_b (rst_b),
    .rx    (u_if.master)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic lvl_j   = 1'b1;
  int   ones    = 0;
  int   gap     = 0;
  bit   sb_on   = 1'b0;
  logic exp_bits[$];
  int   exp_evt[$];

  typedef struct {
    line_state_t ls;
    logic [4:0]  exp;  // {avail, bit_out, done, err, rx_active}
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic samp(input line_state_t ls);
    case (ls)
      LS_J:    {u_if.dp, u_if.dm} = 2'b10;
      LS_K:    {u_if.dp, u_if.dm} = 2'b01;
      LS_SE0:  {u_if.dp, u_if.dm} = 2'b00;
      default: {u_if.dp, u_if.dm} = 2'b11;
    endcase
    u_if.sample_en = 1'b1;
    @(negedge clk);
    u_if.sample_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic raw(input logic b);
    if (!b) lvl_j = ~lvl_j;
    samp(lvl_j ? LS_J : LS_K);
  endtask

  task automatic idle(input int n);
    lvl_j = 1'b1;
    repeat (n) samp(LS_J);
  endtask

  task automatic sync();
    repeat (7) raw(1'b0);
    raw(1'b1);
    ones = 1;
  endtask

  task automatic dbit(input logic b);
    exp_bits.push_back(b);
    raw(b);
    if (b) begin
      ones++;
      if (ones == 6) begin
        raw(1'b0);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic dbyte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) dbit(v[i]);
  endtask

  task automatic eop();
    samp(LS_SE0);
    samp(LS_SE0);
    exp_evt.push_back(EV_DONE);
    lvl_j = 1'b1;
    samp(LS_J);
  endtask

  task automatic recover();
    samp(LS_SE0);
    lvl_j = 1'b1;
    samp(LS_J);
  endtask

  task automatic end_chk(input string name, input logic act);
    @(negedge clk);
    check({name, "_bits_left"}, exp_bits.size(), 0);
    check({name, "_events_left"}, exp_evt.size(), 0);
    check({name, "_rx_active"}, u_if.rx_active, act);
    exp_bits.delete();
    exp_evt.delete();
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      if (u_if.bit_out_avail) begin
        if (exp_bits.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_bit: got %0b expected none", u_if.bit_out);
        end else begin
          check("bit_out", u_if.bit_out, exp_bits.pop_front());
        end
      end
      if (u_if.done || u_if.err) begin
        check("done_err_excl", u_if.done & u_if.err, 0);
        check("avail_in_done", u_if.done & u_if.bit_out_avail, 0);
        if (exp_evt.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: got done=%0b err=%0b code=%0d expected none",
                   u_if.done, u_if.err, u_if.err_code);
        end else begin
          check("event", u_if.done ? EV_DONE : 32'(u_if.err_code), exp_evt.pop_front());
        end
      end
    end
  end

  task automatic add(input line_state_t ls, input logic [4:0] exp);
    vec_t v;
    v.ls  = ls;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    logic b;
    u_if.dp = 1'b1;
    u_if.dm = 1'b0;
    u_if.sample_en = 1'b0;

    // ACK packet: idle, SYNC, PID 0xD2, EOP, one extra idle J
    repeat (4) add(LS_J, 5'b00000);
    add(LS_K, 5'b00000); add(LS_J, 5'b00000); add(LS_K, 5'b00000); add(LS_J, 5'b00000);
    add(LS_K, 5'b00000); add(LS_J, 5'b00000); add(LS_K, 5'b00000); add(LS_K, 5'b00001);
    add(LS_J, 5'b10001); add(LS_J, 5'b11001); add(LS_K, 5'b10001); add(LS_J, 5'b10001);
    add(LS_J, 5'b11001); add(LS_K, 5'b10001); add(LS_K, 5'b11001); add(LS_K, 5'b11001);
    add(LS_SE0, 5'b01001); add(LS_SE0, 5'b01001); add(LS_J, 5'b01100); add(LS_J, 5'b01000);

    repeat (3) @(negedge clk);
    check("reset_outputs", {u_if.bit_out_avail, u_if.bit_out, u_if.done, u_if.err,
                            u_if.rx_active, u_if.err_code}, 0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      samp(tbl[i].ls);
      check($sformatf("vec%0d", i), {u_if.bit_out_avail, u_if.bit_out, u_if.done,
                                      u_if.err, u_if.rx_active}, tbl[i].exp);
    end
    lvl_j = 1'b1;
    sb_on = 1'b1;

    // 0xFF,0x01: stuffed 0 after five data 1s plus SYNC's trailing 1
    idle(2); sync(); dbyte(8'hFF); dbyte(8'h01); eop();
    end_chk("stuff_pkt", 1'b0);

    // Unstuffed 1 at the stuff position, then a clean packet
    idle(2); sync();
    repeat (5) begin exp_bits.push_back(1'b1); raw(1'b1); end
    exp_evt.push_back(int'(ERR_STUFF));
    raw(1'b1);
    recover();
    end_chk("stuff_err", 1'b0);
    idle(2); sync(); dbyte(8'hA5); eop();
    end_chk("after_stuff_err", 1'b0);

    // Bad EOP, then recovery via 8 idle J samples
    idle(2); sync(); dbyte(8'hD2);
    samp(LS_SE0);
    exp_evt.push_back(int'(ERR_EOP));
    lvl_j = 1'b0;
    samp(LS_K);
    idle(8); sync(); dbyte(8'h4B); eop();
    end_chk("eop_err", 1'b0);

    // SE1 inside DATA
    idle(2); sync(); dbyte(8'h3C);
    exp_evt.push_back(int'(ERR_LINE));
    samp(LS_SE1);
    recover();
    end_chk("se1_err", 1'b0);

    // Reset in the middle of a packet
    idle(2); sync(); dbit(1'b0); dbit(1'b1); dbit(1'b1);
    check("pre_reset_active", u_if.rx_active, 1'b1);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1 check("async_reset_outputs", {u_if.bit_out_avail, u_if.bit_out, u_if.done, u_if.err,
                                     u_if.rx_active, u_if.err_code}, 0);
    @(negedge clk);
    check("reset_outputs_hold", {u_if.bit_out_avail, u_if.bit_out, u_if.done, u_if.err,
                                 u_if.rx_active, u_if.err_code}, 0);
    rst_b = 1'b1;
    exp_bits.delete();
    idle(2); sync(); dbyte(8'h69); eop();
    end_chk("after_reset", 1'b0);

    // Length overflow: 99 bits emitted, the 100th errors
    idle(2); sync();
    for (int i = 0; i < 99; i++) dbit(1'($urandom_range(0, 1)));
    check("len_active", u_if.rx_active, 1'b1);
    exp_evt.push_back(int'(ERR_LEN));
    b = 1'($urandom_range(0, 1));
    raw(b);
    recover();
    end_chk("len_err", 1'b0);

    // Repeat stuffing packet with sample_en gaps
    gap = 3;
    idle(2); sync(); dbyte(8'hFF); dbyte(8'h01); eop();
    end_chk("gap_pkt", 1'b0);
    gap = 0;

    sb_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
